// File: rtl/fixed_pkg.sv
// Fixed-point types and arithmetic shared by the vertex pipeline.
// PERSPECTIVE_SATURATE_EN: when defined, fixed_mul clamps instead of wrapping.
package fixed_pkg;

    localparam int unsigned FIXED_WIDTH   = 32;
    localparam int unsigned DECIMAL_WIDTH = 20;
    localparam int unsigned PROD_WIDTH    = 2 * FIXED_WIDTH;

    typedef logic signed [FIXED_WIDTH-1:0] fixed;
    typedef logic signed [PROD_WIDTH-1:0]  fixed_wide;

    localparam fixed FIXED_MAX = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
    localparam fixed FIXED_MIN = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

    // x, y parked while the divider computes 1/z
    typedef struct packed {
        fixed x;
        fixed y;
    } vertex_xy;

    // projected vertex plus 1/z for depth interpolation
    typedef struct packed {
        fixed x;
        fixed y;
        fixed inv_z;
    } projected_vertex;

    // Full-width signed product, rescaled, then narrowed (wrap or clamp)
    function automatic fixed fixed_mul(input fixed a, input fixed b);
        fixed_wide prod;
        prod = (PROD_WIDTH'(a) * PROD_WIDTH'(b)) >>> DECIMAL_WIDTH;
`ifdef PERSPECTIVE_SATURATE_EN
        if (prod > PROD_WIDTH'(FIXED_MAX)) return FIXED_MAX;
        if (prod < PROD_WIDTH'(FIXED_MIN)) return FIXED_MIN;
`endif
        return FIXED_WIDTH'(prod);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and decoded full/empty.
// Head entry is presented combinationally (show-ahead).
module sync_fifo #(
    parameter  int unsigned WIDTH   = 64,
    parameter  int unsigned DEPTH   = 32,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               push_ok;
    logic               pop_ok;

    // Flags from the registered count; no bypass when full
    always_comb begin
        full_c  = (count == COUNT_W'(DEPTH));
        empty_c = (count == '0);
        push_ok = push && !full_c;
        pop_ok  = pop && !empty_c;
        rdata_c = mem[rd_ptr];
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/perspective_projector.sv
// Perspective divide: forwards z to the reciprocal divider, parks x/y in order,
// and scales them by the returned 1/z.
// PERSPECTIVE_SATURATE_EN: clamp x/z, y/z on overflow instead of wrapping.
module perspective_projector
    import fixed_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          in_ready,
    input  logic                          in_valid,
    input  logic signed [FIXED_WIDTH-1:0] in_x,
    input  logic signed [FIXED_WIDTH-1:0] in_y,
    input  logic signed [FIXED_WIDTH-1:0] in_z,
    input  logic                          divisor_m_ready,
    output logic                          divisor_m_valid,
    output logic signed [FIXED_WIDTH-1:0] divisor_m_data,
    output logic                          result_s_ready,
    input  logic                          result_s_valid,
    input  logic signed [FIXED_WIDTH-1:0] result_s_data,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic signed [FIXED_WIDTH-1:0] out_x,
    output logic signed [FIXED_WIDTH-1:0] out_y,
    output logic signed [FIXED_WIDTH-1:0] out_inv_z
);

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    vertex_xy        wr_entry;
    vertex_xy        head;
    projected_vertex out_q;

    // Handshakes; a result arriving with nothing pending is an orphan and is dropped
    always_comb begin
        divisor_m_valid = in_valid && !full;
        in_ready        = !full && divisor_m_ready;
        push            = in_valid && in_ready;
        divisor_m_data  = in_z;
        result_s_ready  = empty || !out_valid || out_ready;
        pop             = result_s_valid && result_s_ready && !empty;
        wr_entry        = '{x: in_x, y: in_y};
    end

    sync_fifo #(
        .WIDTH ($bits(vertex_xy)),
        .DEPTH (FIFO_DEPTH)
    ) u_pending (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (wr_entry),
        .pop     (pop),
        .rdata_c (head),
        .full_c  (full),
        .empty_c (empty)
    );

    // Output register: load on pop, clear on drain, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_q     <= '{x:     fixed_mul(head.x, result_s_data),
                           y:     fixed_mul(head.y, result_s_data),
                           inv_z: result_s_data};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_x     = out_q.x;
    assign out_y     = out_q.y;
    assign out_inv_z = out_q.inv_z;

endmodule

// File: tb/tb_perspective_projector.sv
// Bench for perspective_projector with a latency-configurable divider model.
module tb_perspective_projector;
    import fixed_pkg::*;

    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    logic in_ready, in_valid;
    fixed in_x, in_y, in_z;
    logic divisor_m_ready, divisor_m_valid;
    fixed divisor_m_data;
    logic result_s_ready, result_s_valid;
    fixed result_s_data;
    logic out_ready, out_valid;
    fixed out_x, out_y, out_inv_z;

    perspective_projector #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_ready        (in_ready),
        .in_valid        (in_valid),
        .in_x            (in_x),
        .in_y            (in_y),
        .in_z            (in_z),
        .divisor_m_ready (divisor_m_ready),
        .divisor_m_valid (divisor_m_valid),
        .divisor_m_data  (divisor_m_data),
        .result_s_ready  (result_s_ready),
        .result_s_valid  (result_s_valid),
        .result_s_data   (result_s_data),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_inv_z       (out_inv_z)
    );

    always #5 clk = ~clk;

    typedef struct { fixed x; fixed y; } pend_t;
    typedef struct { fixed data; int due; } div_t;
    typedef struct { fixed x; fixed y; fixed z; fixed inv; fixed ex; fixed ey; } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    div_lat = 8;
    int    n_push = 0;
    int    n_out = 0;
    pend_t pend_q[$];
    div_t  div_q[$];
    bit    has_out = 1'b0;
    fixed  cur_x, cur_y, cur_inv;
    fixed  stim_inv;

    function automatic fixed fx(input real r);
        return fixed'($rtoi(r * 1048576.0));
    endfunction

    // Reference product: exact integer multiply, floor rescale, wrap or clamp
    function automatic fixed ref_mul(input fixed a, input fixed b);
        longint p;
        longint s;
        p = longint'(a) * longint'(b);
        s = p >>> DECIMAL_WIDTH;
`ifdef PERSPECTIVE_SATURATE_EN
        if (s > 64'sd2147483647)  return fixed'(32'h7FFFFFFF);
        if (s < -64'sd2147483648) return fixed'(32'h80000000);
`endif
        return fixed'(s[31:0]);
    endfunction

    function automatic fixed recip(input fixed z);
        longint q;
        if (z == 0) return fixed'(32'h7FFFFFFF);
        q = (longint'(1) <<< 40) / longint'(z);
        return fixed'(q[31:0]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_div();
        if (div_q.size() > 0 && div_q[0].due <= cyc) begin
            result_s_valid = 1'b1;
            result_s_data  = div_q[0].data;
        end else begin
            result_s_valid = 1'b0;
            result_s_data  = '0;
        end
    endtask

    task automatic set_rand_vertex();
        int unsigned mag;
        in_x = fixed'($urandom) >>> $urandom_range(2, 14);
        in_y = fixed'($urandom) >>> $urandom_range(2, 14);
        mag  = $urandom_range(32'd1 << 18, 32'd1 << 26);
        in_z = ($urandom_range(0, 1) == 1) ? -fixed'(mag) : fixed'(mag);
        stim_inv = recip(in_z);
    endtask

    // One clock: check against the model, advance model on the edge, drive divider
    task automatic step();
        bit   push_f, res_f, out_f;
        bit   room;
        div_t e;
        pend_t p;
        #1;
        room = (pend_q.size() < DEPTH);
        if (!rst) begin
            chk("divisor_m_valid", divisor_m_valid, in_valid && room);
            chk("in_ready", in_ready, room && divisor_m_ready);
            chk("result_s_ready", result_s_ready, pend_q.size() == 0 || !has_out || out_ready);
            chk("out_valid", out_valid, has_out);
            if (in_valid && room) chk("divisor_m_data", divisor_m_data, in_z);
            if (has_out) begin
                chk("out_x", out_x, cur_x);
                chk("out_y", out_y, cur_y);
                chk("out_inv_z", out_inv_z, cur_inv);
            end
        end
        push_f = !rst && in_valid && room && divisor_m_ready;
        res_f  = result_s_valid && (rst || pend_q.size() == 0 || !has_out || out_ready);
        out_f  = !rst && has_out && out_ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            if (res_f) void'(div_q.pop_front());
        end else begin
            if (out_f) begin
                n_out++;
                has_out = 1'b0;
            end
            if (res_f) begin
                e = div_q.pop_front();
                if (pend_q.size() > 0) begin
                    p = pend_q.pop_front();
                    cur_x   = ref_mul(p.x, e.data);
                    cur_y   = ref_mul(p.y, e.data);
                    cur_inv = e.data;
                    has_out = 1'b1;
                end
            end
            if (push_f) begin
                pend_q.push_back('{x: in_x, y: in_y});
                div_q.push_back('{data: stim_inv, due: cyc + div_lat});
                n_push++;
            end
        end
        @(negedge clk);
        drive_div();
    endtask

    task automatic run_idle(input int budget);
        int k;
        in_valid = 1'b0;
        k = 0;
        while ((pend_q.size() > 0 || div_q.size() > 0 || has_out) && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (pend_q.size() > 0 || div_q.size() > 0 || has_out) begin
            errors++;
            $display("FAIL drain_timeout: pending %0d divider %0d after %0d cycles",
                     pend_q.size(), div_q.size(), budget);
        end
    endtask

    task automatic wait_out(input string name, input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout: out_valid got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   push_at, out0, push0;
        bit   burst_checked;
        int   k;

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0;
        divisor_m_ready = 1'b1; result_s_valid = 1'b0; result_s_data = '0;
        out_ready = 1'b1; stim_inv = '0;
        step();
        step();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_x", out_x, 32'h0);
        chk("reset_out_y", out_y, 32'h0);
        chk("reset_out_inv_z", out_inv_z, 32'h0);
        chk("reset_divisor_valid", divisor_m_valid, 1'b0);
        rst = 1'b0;

        // Directed vectors with hand-derived results
        vecs[0] = '{fx(2.0),    fx(-1.0), fx(4.0),  fx(0.25), fx(0.5),  fx(-0.25)};
        vecs[1] = '{fx(1.0),    fx(1.0),  fx(2.0),  fx(0.5),  fx(0.5),  fx(0.5)};
        vecs[2] = '{fx(3.0),    fx(-2.0), fx(0.5),  fx(2.0),  fx(6.0),  fx(-4.0)};
        vecs[3] = '{fx(-1.5),   fx(0.75), fx(-2.0), fx(-0.5), fx(0.75), fx(-0.375)};
`ifdef PERSPECTIVE_SATURATE_EN
        vecs[4] = '{fx(100.0),  fx(1.0),  fx(0.01), fx(100.0), fixed'(32'h7FFFFFFF), fx(100.0)};
        vecs[5] = '{fx(-100.0), fx(0.0),  fx(0.01), fx(100.0), fixed'(32'h80000000), fx(0.0)};
`else
        vecs[4] = '{fx(100.0),  fx(1.0),  fx(0.01), fx(100.0), fixed'(32'h71000000), fx(100.0)};
        vecs[5] = '{fx(-100.0), fx(0.0),  fx(0.01), fx(100.0), fixed'(32'h8F000000), fx(0.0)};
`endif
        div_lat = 8;
        for (int i = 0; i < 6; i++) begin
            in_x = vecs[i].x; in_y = vecs[i].y; in_z = vecs[i].z;
            stim_inv = vecs[i].inv;
            in_valid = 1'b1;
            step();
            push_at = cyc;
            in_valid = 1'b0;
            wait_out("vec", 50);
            chk("vec_latency", 64'(cyc - push_at), 64'(div_lat + 1));
            chk("vec_out_x", out_x, vecs[i].ex);
            chk("vec_out_y", out_y, vecs[i].ey);
            chk("vec_out_inv_z", out_inv_z, vecs[i].inv);
            run_idle(100);
        end

        // Divider not ready: request shown, nothing accepted
        divisor_m_ready = 1'b0;
        set_rand_vertex();
        in_valid = 1'b1;
        #1;
        chk("dstall_divisor_valid", divisor_m_valid, 1'b1);
        chk("dstall_in_ready", in_ready, 1'b0);
        step();
        step();
        divisor_m_ready = 1'b1;
        in_x = fx(1.0); in_y = fx(-3.0); in_z = fx(2.0); stim_inv = fx(0.5);
        step();
        in_valid = 1'b0;
        wait_out("dstall", 50);
        chk("dstall_next_x", out_x, fx(0.5));
        chk("dstall_next_y", out_y, fx(-1.5));
        run_idle(100);

        // Burst of 40 against a slow divider: FIFO fills, then drains in order
        div_lat = 40;
        out_ready = 1'b1;
        push0 = n_push; out0 = n_out;
        burst_checked = 1'b0;
        in_valid = 1'b1;
        k = 0;
        while (n_push - push0 < 40 && k < 400) begin
            set_rand_vertex();
            step();
            k++;
            if (n_push - push0 == 32 && !burst_checked) begin
                chk("burst_full_in_ready", in_ready, 1'b0);
                burst_checked = 1'b1;
            end
        end
        run_idle(300);
        chk("burst_outputs", 64'(n_out - out0), 64'd40);

        // Downstream stall: output holds, FIFO fills to capacity
        div_lat = 4;
        out_ready = 1'b0;
        push0 = n_push; out0 = n_out;
        in_valid = 1'b1;
        repeat (45) begin
            set_rand_vertex();
            step();
        end
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_result_ready", result_s_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        chk("stall_accepted", 64'(n_push - push0), 64'(DEPTH + 1));
        in_valid = 1'b0;
        out_ready = 1'b1;
        run_idle(300);
        chk("stall_outputs", 64'(n_out - out0), 64'(DEPTH + 1));

        // Reset with three results in flight: they come back as orphans
        div_lat = 8;
        out_ready = 1'b0;
        set_rand_vertex();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("pre_reset", 50);
        in_valid = 1'b1;
        repeat (3) begin
            set_rand_vertex();
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_out_x", out_x, 32'h0);
        has_out = 1'b0;
        pend_q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        out0 = n_out;
        run_idle(100);
        chk("orphan_no_output", 64'(n_out - out0), 64'd0);
        chk("orphan_out_valid", out_valid, 1'b0);
        in_x = fx(1.0); in_y = fx(1.0); in_z = fx(2.0); stim_inv = fx(0.5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("post_reset", 50);
        chk("post_reset_x", out_x, fx(0.5));
        chk("post_reset_y", out_y, fx(0.5));
        chk("post_reset_inv_z", out_inv_z, fx(0.5));
        run_idle(100);

        // Randomized traffic against the reference model
        for (int r = 0; r < 3; r++) begin
            div_lat = $urandom_range(1, 12);
            push0 = n_push; out0 = n_out;
            repeat (300) begin
                set_rand_vertex();
                in_valid        = ($urandom_range(0, 3) != 0);
                divisor_m_ready = ($urandom_range(0, 4) != 0);
                out_ready       = ($urandom_range(0, 9) < 7);
                step();
            end
            divisor_m_ready = 1'b1;
            out_ready = 1'b1;
            run_idle(400);
            chk("random_all_out", 64'(n_out - out0), 64'(n_push - push0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
